// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register select codes, inc/dec pair codes and flag
// bit positions used by both the register bank and the ALU.
package cpu_pkg;

  localparam logic [3:0] REG_B  = 4'h0;
  localparam logic [3:0] REG_C  = 4'h1;
  localparam logic [3:0] REG_D  = 4'h2;
  localparam logic [3:0] REG_E  = 4'h3;
  localparam logic [3:0] REG_H  = 4'h4;
  localparam logic [3:0] REG_L  = 4'h5;
  localparam logic [3:0] REG_F  = 4'h6;
  localparam logic [3:0] REG_A  = 4'h7;
  localparam logic [3:0] REG_BC = 4'h8;
  localparam logic [3:0] REG_DE = 4'h9;
  localparam logic [3:0] REG_HL = 4'hA;
  localparam logic [3:0] REG_AF = 4'hB;
  localparam logic [3:0] REG_SP = 4'hC;
  localparam logic [3:0] REG_PC = 4'hD;

  localparam logic [1:0] ID_BC = 2'd0;
  localparam logic [1:0] ID_DE = 2'd1;
  localparam logic [1:0] ID_HL = 2'd2;
  localparam logic [1:0] ID_SP = 2'd3;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/reg_incdec16.sv
// Combinational 16-bit +1/-1, wrapping modulo 2^16.
module reg_incdec16 (
  input  logic [15:0] a,
  input  logic        dec,
  output logic [15:0] y
);

  assign y = dec ? (a - 16'd1) : (a + 16'd1);

endmodule

// File: rtl/cpu_regbank.sv
// Game Boy register file: two combinational operand ports, flag merge from
// the ALU, and inc/dec paths for PC and the BC/DE/HL/SP pairs.
module cpu_regbank
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_INIT = 16'h0000,
  parameter logic [15:0] SP_INIT = 16'hFFFE,
  parameter logic [15:0] AF_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rdSelX,
  input  logic [3:0]  rdSelY,
  output logic [15:0] X,
  output logic [15:0] Y,
  output logic [3:0]  flags,
  input  logic        wrEn,
  input  logic [3:0]  wrSel,
  input  logic [15:0] wrData,
  input  logic [3:0]  flagWrMask,
  input  logic [3:0]  flagIn,
  input  logic        pcInc,
  input  logic        idEn,
  input  logic [1:0]  idSel,
  input  logic        idDec,
  output logic [15:0] pc,
  output logic [15:0] sp,
  output logic [15:0] hl
);

  logic [7:0]  b, c, d, e, h, l, a, f;
  logic [15:0] sp_q, pc_q;
  logic [7:0]  b_n, c_n, d_n, e_n, h_n, l_n, a_n, f_n;
  logic [15:0] sp_n, pc_n;
  logic [15:0] id_src, id_res, pc_res;
  logic [15:0] rd_tab [16];

  always_comb begin
    id_src = {b, c};
    case (idSel)
      ID_DE:   id_src = {d, e};
      ID_HL:   id_src = {h, l};
      ID_SP:   id_src = sp_q;
      default: id_src = {b, c};
    endcase
  end

  reg_incdec16 u_id_incdec (.a(id_src), .dec(idDec), .y(id_res));
  reg_incdec16 u_pc_incdec (.a(pc_q),   .dec(1'b0),  .y(pc_res));

  // Lowest priority first; later assignments override earlier ones.
  always_comb begin
    b_n = b; c_n = c; d_n = d; e_n = e;
    h_n = h; l_n = l; a_n = a; f_n = f;
    sp_n = sp_q; pc_n = pc_q;
    if (idEn) begin
      case (idSel)
        ID_BC:   {b_n, c_n} = id_res;
        ID_DE:   {d_n, e_n} = id_res;
        ID_HL:   {h_n, l_n} = id_res;
        default: sp_n = id_res;
      endcase
    end
    if (pcInc) pc_n = pc_res;
    if (wrEn) begin
      case (wrSel)
        REG_B:   b_n = wrData[7:0];
        REG_C:   c_n = wrData[7:0];
        REG_D:   d_n = wrData[7:0];
        REG_E:   e_n = wrData[7:0];
        REG_H:   h_n = wrData[7:0];
        REG_L:   l_n = wrData[7:0];
        REG_F:   f_n = wrData[7:0];
        REG_A:   a_n = wrData[7:0];
        REG_BC:  {b_n, c_n} = wrData;
        REG_DE:  {d_n, e_n} = wrData;
        REG_HL:  {h_n, l_n} = wrData;
        REG_AF:  {a_n, f_n} = wrData;
        REG_SP:  sp_n = wrData;
        REG_PC:  pc_n = wrData;
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      if (flagWrMask[i]) f_n[4+i] = flagIn[i];
    end
    f_n[3:0] = 4'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b <= 8'h00; c <= 8'h00; d <= 8'h00; e <= 8'h00;
      h <= 8'h00; l <= 8'h00;
      a <= AF_INIT[15:8];
      f <= {AF_INIT[7:4], 4'h0};
      sp_q <= SP_INIT;
      pc_q <= PC_INIT;
    end else begin
      b <= b_n; c <= c_n; d <= d_n; e <= e_n;
      h <= h_n; l <= l_n; a <= a_n; f <= f_n;
      sp_q <= sp_n;
      pc_q <= pc_n;
    end
  end

  // Read table indexed directly by the select; E and F slots read zero.
  always_comb begin
    for (int i = 0; i < 16; i++) rd_tab[i] = 16'h0000;
    rd_tab[REG_B]  = {8'h00, b};
    rd_tab[REG_C]  = {8'h00, c};
    rd_tab[REG_D]  = {8'h00, d};
    rd_tab[REG_E]  = {8'h00, e};
    rd_tab[REG_H]  = {8'h00, h};
    rd_tab[REG_L]  = {8'h00, l};
    rd_tab[REG_F]  = {8'h00, f};
    rd_tab[REG_A]  = {8'h00, a};
    rd_tab[REG_BC] = {b, c};
    rd_tab[REG_DE] = {d, e};
    rd_tab[REG_HL] = {h, l};
    rd_tab[REG_AF] = {a, f};
    rd_tab[REG_SP] = sp_q;
    rd_tab[REG_PC] = pc_q;
  end

  assign X     = rd_tab[rdSelX];
  assign Y     = rd_tab[rdSelY];
  assign flags = f[7:4];
  assign pc    = pc_q;
  assign sp    = sp_q;
  assign hl    = {h, l};

endmodule

// File: tb/tb_cpu_regbank.sv
// Directed bench for cpu_regbank: reset values, writes, pair access,
// wraparound, same-edge priority and reset override.
module tb_cpu_regbank;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rdSelX, rdSelY;
  logic [15:0] X, Y;
  logic [3:0]  flags;
  logic        wrEn;
  logic [3:0]  wrSel;
  logic [15:0] wrData;
  logic [3:0]  flagWrMask, flagIn;
  logic        pcInc, idEn, idDec;
  logic [1:0]  idSel;
  logic [15:0] pc, sp, hl;

  int vectors = 0;
  int miscompares = 0;

  cpu_regbank dut (
    .clk(clk), .reset(reset),
    .rdSelX(rdSelX), .rdSelY(rdSelY), .X(X), .Y(Y), .flags(flags),
    .wrEn(wrEn), .wrSel(wrSel), .wrData(wrData),
    .flagWrMask(flagWrMask), .flagIn(flagIn),
    .pcInc(pcInc), .idEn(idEn), .idSel(idSel), .idDec(idDec),
    .pc(pc), .sp(sp), .hl(hl)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; wrEn = 1'b0; wrSel = 4'h0; wrData = 16'h0000;
    flagWrMask = 4'h0; flagIn = 4'h0;
    pcInc = 1'b0; idEn = 1'b0; idSel = 2'd0; idDec = 1'b0;
  endtask

  // One active edge, then strobes return to idle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic write(input logic [3:0] sel, input logic [15:0] data);
    wrEn = 1'b1; wrSel = sel; wrData = data;
    step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    rdSelX = REG_B; rdSelY = REG_AF; #1;
    vectors++; if (sp !== 16'hFFFE) begin miscompares++; $display("FAIL reset_sp got %h exp %h", sp, 16'hFFFE); end
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0000); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp %b", flags, 4'b0000); end
    vectors++; if (X !== 16'h0000) begin miscompares++; $display("FAIL reset_x_b got %h exp %h", X, 16'h0000); end
    vectors++; if (Y !== 16'h0000) begin miscompares++; $display("FAIL reset_y_af got %h exp %h", Y, 16'h0000); end
    vectors++; if (hl !== 16'h0000) begin miscompares++; $display("FAIL reset_hl got %h exp %h", hl, 16'h0000); end
  endtask

  task automatic test_af_write();
    write(REG_AF, 16'h12FF);
    rdSelX = REG_AF; rdSelY = REG_A; #1;
    vectors++; if (X !== 16'h12F0) begin miscompares++; $display("FAIL af_x got %h exp %h", X, 16'h12F0); end
    vectors++; if (flags !== 4'b1111) begin miscompares++; $display("FAIL af_flags got %b exp %b", flags, 4'b1111); end
    vectors++; if (Y !== 16'h0012) begin miscompares++; $display("FAIL a_zext got %h exp %h", Y, 16'h0012); end
    rdSelY = REG_F; #1;
    vectors++; if (Y !== 16'h00F0) begin miscompares++; $display("FAIL f_read got %h exp %h", Y, 16'h00F0); end
  endtask

  task automatic test_hl_pair();
    write(REG_H, 16'hAB80);
    write(REG_L, 16'hCD01);
    rdSelX = REG_HL; #1;
    vectors++; if (X !== 16'h8001) begin miscompares++; $display("FAIL hl_pair got %h exp %h", X, 16'h8001); end
    idEn = 1'b1; idSel = ID_HL; idDec = 1'b1;
    step();
    vectors++; if (hl !== 16'h8000) begin miscompares++; $display("FAIL hl_dec got %h exp %h", hl, 16'h8000); end
    vectors++; if (flags !== 4'b1111) begin miscompares++; $display("FAIL hl_dec_flags got %b exp %b", flags, 4'b1111); end
  endtask

  task automatic test_wrap();
    write(REG_SP, 16'h0000);
    idEn = 1'b1; idSel = ID_SP; idDec = 1'b1;
    step();
    vectors++; if (sp !== 16'hFFFF) begin miscompares++; $display("FAIL sp_wrap got %h exp %h", sp, 16'hFFFF); end
    vectors++; if (flags !== 4'b1111) begin miscompares++; $display("FAIL sp_wrap_flags got %b exp %b", flags, 4'b1111); end
    write(REG_PC, 16'hFFFF);
    pcInc = 1'b1;
    step();
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL pc_wrap got %h exp %h", pc, 16'h0000); end
    vectors++; if (flags !== 4'b1111) begin miscompares++; $display("FAIL pc_wrap_flags got %b exp %b", flags, 4'b1111); end
    // BC increment carries across the byte boundary.
    write(REG_BC, 16'h00FF);
    idEn = 1'b1; idSel = ID_BC; idDec = 1'b0;
    step();
    rdSelX = REG_BC; rdSelY = REG_B; #1;
    vectors++; if (X !== 16'h0100) begin miscompares++; $display("FAIL bc_inc got %h exp %h", X, 16'h0100); end
    vectors++; if (Y !== 16'h0001) begin miscompares++; $display("FAIL b_after_inc got %h exp %h", Y, 16'h0001); end
  endtask

  task automatic test_same_edge();
    wrEn = 1'b1; wrSel = REG_AF; wrData = 16'h00F0;
    flagWrMask = 4'b0101; flagIn = 4'b0000;
    step();
    vectors++; if (flags !== 4'b1010) begin miscompares++; $display("FAIL merge_flags got %b exp %b", flags, 4'b1010); end
    wrEn = 1'b1; wrSel = REG_PC; wrData = 16'h0200; pcInc = 1'b1;
    step();
    vectors++; if (pc !== 16'h0200) begin miscompares++; $display("FAIL wr_over_inc got %h exp %h", pc, 16'h0200); end
    // hl is 8000 from earlier; all four independent updates commit together.
    wrEn = 1'b1; wrSel = REG_A; wrData = 16'hFF33;
    flagWrMask = 4'b1000; flagIn = 4'b0000;
    pcInc = 1'b1; idEn = 1'b1; idSel = ID_HL; idDec = 1'b0;
    step();
    rdSelX = REG_A; #1;
    vectors++; if (X !== 16'h0033) begin miscompares++; $display("FAIL combo_a got %h exp %h", X, 16'h0033); end
    vectors++; if (flags !== 4'b0010) begin miscompares++; $display("FAIL combo_flags got %b exp %b", flags, 4'b0010); end
    vectors++; if (pc !== 16'h0201) begin miscompares++; $display("FAIL combo_pc got %h exp %h", pc, 16'h0201); end
    vectors++; if (hl !== 16'h8001) begin miscompares++; $display("FAIL combo_hl got %h exp %h", hl, 16'h8001); end
  endtask

  task automatic test_unused_sel();
    write(REG_DE, 16'h1234);
    wrEn = 1'b1; wrSel = 4'hE; wrData = 16'hFFFF;
    step();
    wrEn = 1'b1; wrSel = 4'hF; wrData = 16'hFFFF;
    step();
    rdSelX = REG_DE; rdSelY = 4'hE; #1;
    vectors++; if (X !== 16'h1234) begin miscompares++; $display("FAIL de_hold got %h exp %h", X, 16'h1234); end
    vectors++; if (Y !== 16'h0000) begin miscompares++; $display("FAIL sel_e got %h exp %h", Y, 16'h0000); end
    rdSelY = 4'hF; #1;
    vectors++; if (Y !== 16'h0000) begin miscompares++; $display("FAIL sel_f got %h exp %h", Y, 16'h0000); end
    vectors++; if (sp !== 16'hFFFF) begin miscompares++; $display("FAIL sp_hold got %h exp %h", sp, 16'hFFFF); end
  endtask

  task automatic test_reset_priority();
    write(REG_B, 16'h0077);
    reset = 1'b1; wrEn = 1'b1; wrSel = REG_B; wrData = 16'h55AA; pcInc = 1'b1;
    flagWrMask = 4'b1111; flagIn = 4'b1111;
    rdSelX = REG_B; #1;
    vectors++; if (X !== 16'h0077) begin miscompares++; $display("FAIL no_bypass got %h exp %h", X, 16'h0077); end
    vectors++; if (flags !== 4'b0010) begin miscompares++; $display("FAIL no_flag_bypass got %b exp %b", flags, 4'b0010); end
    step();
    vectors++; if (X !== 16'h0000) begin miscompares++; $display("FAIL rst_b got %h exp %h", X, 16'h0000); end
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rst_pc got %h exp %h", pc, 16'h0000); end
    vectors++; if (sp !== 16'hFFFE) begin miscompares++; $display("FAIL rst_sp got %h exp %h", sp, 16'hFFFE); end
    vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL rst_flags got %b exp %b", flags, 4'b0000); end
    vectors++; if (hl !== 16'h0000) begin miscompares++; $display("FAIL rst_hl got %h exp %h", hl, 16'h0000); end
  endtask

  initial begin
    idle();
    rdSelX = REG_B; rdSelY = REG_B;
    @(negedge clk);
    test_reset();
    test_af_write();
    test_hl_pair();
    test_wrap();
    test_same_edge();
    test_unused_sel();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
